pa_sysmap_busif: RTL and testbench
==================================

PA_SYSMAP_BUSIF -- requirements
Module: pa_sysmap_busif

Interface
REQ-001 SHALL use clock sysmap_clk and reset cpurst_b (asynchronous, active-low), as already decided.
REQ-002 SHALL have ports:
- sysmap_clk  in  1  clock
- cpurst_b  in  1  async active-low reset
- bus_sysmap_sel  in  1  request valid, held until ready
- bus_sysmap_write  in  1  1=write, 0=read
- bus_sysmap_addr  in  12  byte offset; bits [1:0] ignored
- bus_sysmap_wdata  in  32  write data
- sysmap_bus_ready  out  1  one-cycle completion pulse
- sysmap_bus_rdata  out  32  read data, valid with ready
- sysmap_bus_err  out  1  error, valid with ready
- ifu_sysmap_rst_sample  in  1  register reset-sample in progress
- busif_base_addr_values  in  256  8 x 32b region base readback, region x at [32x+31:32x]
- busif_flg_values  in  256  8 x 32b region flag readback
- busif_base_addr_updt  out  8  one-hot base write strobe per region
- busif_flg_updt  out  8  one-hot flag write strobe per region
- busif_wdata  out  32  registered write data to region registers

Function
REQ-003 SHALL decode the map: offset 0x00+8x is region x base (x=0..7), 0x04+8x is region x flag, 0x40 is the lock register (only with SYSMAP_WR_LOCK_EN); any other offset is unmapped.
REQ-004 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; reset state IDLE.
REQ-005 SHALL, in IDLE with sel=1, register addr, write and wdata and move to ACCESS next cycle.
REQ-006 SHALL, in ACCESS with ifu_sysmap_rst_sample=0, pulse exactly one updt bit for one cycle on a mapped, unlocked write; then go to RESP.
REQ-007 SHALL stay in ACCESS with all updt low while ifu_sysmap_rst_sample=1; the strobe issues in the first ACCESS cycle after it drops.
REQ-008 SHALL capture rdata in the ACCESS cycle that leaves ACCESS; a read returns the selected value; a write returns 0.
REQ-009 SHALL assert ready for exactly one cycle in RESP, with err=1 for unmapped offsets or for writes blocked by lock; err=0 otherwise.
REQ-010 SHALL, for a read of an unmapped offset, return rdata=0 with err=1.
REQ-011 SHALL give a nominal latency of 2 cycles from the sel sample edge to ready, plus one cycle per cycle of rst_sample stall.
REQ-012 SHALL return to IDLE after RESP and accept a new request no earlier than the cycle after ready; a still-high sel in IDLE is a new request.
REQ-013 SHALL ignore sel changes while in ACCESS or RESP.
REQ-014 SHALL drive busif_wdata from the registered wdata, stable from ACCESS entry through RESP.

Reset
REQ-015 SHALL reset with state=IDLE, ready=0, err=0, rdata=0, all updt=0, busif_wdata=0 and lock=0.
REQ-016 SHALL abort any transaction in flight on reset assertion; no strobe or ready follows reset release until a new sel.

Configuration
REQ-017 SHALL, with SYSMAP_WR_LOCK_EN defined, implement lock register bit 0 at 0x40:
- write-1 sets it; write-0 has no effect
- readable
- once set, base/flag writes give err=1 and no strobe until cpurst_b
- reads stay allowed
REQ-018 SHALL, without SYSMAP_WR_LOCK_EN, have no lock flop; 0x40 is unmapped.

Structure
REQ-019 SHALL place the following in a shared package pa_sysmap_pkg, also used by pa_sysmap_top: region count (8), offset constants (BASE 0x0, FLG 0x4, STRIDE 0x8, LOCK 0x40) and the FSM state encoding.
REQ-020 SHALL use one sub-module, pa_sysmap_busif_dec: a combinational offset-to-one-hot region/kind/valid decoder.

Verification
REQ-021 SHALL cover: write 0x18 wdata 0x0001_2345 -> busif_base_addr_updt=8'h08 one cycle later, ready 2 cycles after sel, err=0.
REQ-022 SHALL cover: read 0x24 with busif_flg_values[4]=0x1C -> rdata=0x0000_001C, err=0, no strobes.
REQ-023 SHALL cover: read 0x3FC -> ready with err=1, rdata=0.
REQ-024 SHALL cover: write 0x00 with rst_sample high 3 cycles at ACCESS entry -> strobe delayed 3 cycles, ready at cycle 5.
REQ-025 SHALL cover: with SYSMAP_WR_LOCK_EN, write 0x40=1 then write 0x08 -> err=1, no strobe; read 0x40 -> 1; reset clears lock.
REQ-026 SHALL cover: cpurst_b asserted in ACCESS -> no strobe, no ready; back-to-back reads with sel held -> ready every 3 cycles.

Source files
------------

// File: rtl/pa_sysmap_pkg.sv
// Shared constants and types for the system-map register block (region map, offsets, FSM encoding).
package pa_sysmap_pkg;

   localparam int          REGION_NUM    = 8;
   localparam logic [11:0] BASE_OFS      = 12'h000;
   localparam logic [11:0] FLG_OFS       = 12'h004;
   localparam logic [11:0] REGION_STRIDE = 12'h008;
   localparam logic [11:0] LOCK_OFS      = 12'h040;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } sysmap_state_e;

   typedef enum logic [1:0] {
      KIND_BASE = 2'd0,
      KIND_FLG  = 2'd1,
      KIND_LOCK = 2'd2,
      KIND_NONE = 2'd3
   } sysmap_kind_e;

   typedef struct packed {
      logic                  valid;
      sysmap_kind_e          kind;
      logic [REGION_NUM-1:0] region;
   } sysmap_dec_t;

   function automatic logic [11:0] region_ofs(input int idx, input logic [11:0] kind_ofs);
      return kind_ofs + 12'(idx) * REGION_STRIDE;
   endfunction

endpackage

// File: rtl/pa_sysmap_busif_if.sv
// Request/response handshake between a bus master and the system-map register block.
interface pa_sysmap_busif_if;

   logic        bus_sysmap_sel;
   logic        bus_sysmap_write;
   logic [11:0] bus_sysmap_addr;
   logic [31:0] bus_sysmap_wdata;
   logic        sysmap_bus_ready;
   logic [31:0] sysmap_bus_rdata;
   logic        sysmap_bus_err;

   modport master (
      output bus_sysmap_sel, bus_sysmap_write, bus_sysmap_addr, bus_sysmap_wdata,
      input  sysmap_bus_ready, sysmap_bus_rdata, sysmap_bus_err
   );

   modport slave (
      input  bus_sysmap_sel, bus_sysmap_write, bus_sysmap_addr, bus_sysmap_wdata,
      output sysmap_bus_ready, sysmap_bus_rdata, sysmap_bus_err
   );

endinterface

// File: rtl/pa_sysmap_busif_dec.sv
// Combinational offset decoder: one-hot region, register kind and hit flag.
// The lock register at 0x40 decodes only when SYSMAP_WR_LOCK_EN is defined.
module pa_sysmap_busif_dec
   import pa_sysmap_pkg::*;
(
   input  logic [11:0] addr,
   output sysmap_dec_t dec
);

   logic [11:0] ofs;

   // Word-aligned offset; byte lanes within a register are not distinguished.
   assign ofs = addr & 12'hFFC;

   always_comb begin
      // NOTE: default every field first so no path through the block can infer a latch.
      dec = '{valid: 1'b0, kind: KIND_NONE, region: '0};
      for (int i = 0; i < REGION_NUM; i++) begin
         if (ofs == region_ofs(i, BASE_OFS)) begin
            dec.valid     = 1'b1;
            dec.kind      = KIND_BASE;
            dec.region[i] = 1'b1;
         end
         if (ofs == region_ofs(i, FLG_OFS)) begin
            dec.valid     = 1'b1;
            dec.kind      = KIND_FLG;
            dec.region[i] = 1'b1;
         end
      end
`ifdef SYSMAP_WR_LOCK_EN
      if (ofs == LOCK_OFS) begin
         dec.valid = 1'b1;
         dec.kind  = KIND_LOCK;
      end
`endif
   end

endmodule

// File: rtl/pa_sysmap_busif.sv
// Bus slave for the system-map region registers: IDLE -> ACCESS -> RESP handshake.
// Optional write lock at 0x40 is built when SYSMAP_WR_LOCK_EN is defined.
module pa_sysmap_busif
   import pa_sysmap_pkg::*;
(
   input  logic                 sysmap_clk,
   input  logic                 cpurst_b,
   pa_sysmap_busif_if.slave     bus,
   input  logic                 ifu_sysmap_rst_sample,
   input  logic [255:0]         busif_base_addr_values,
   input  logic [255:0]         busif_flg_values,
   output logic [7:0]           busif_base_addr_updt,
   output logic [7:0]           busif_flg_updt,
   output logic [31:0]          busif_wdata
);

   sysmap_state_e state;
   logic [11:0]   addr_q;
   logic          write_q;
   logic          lock;
   sysmap_dec_t   dec;
   logic          access_go;
   logic          blocked;
   logic          acc_err;
   logic          wr_ok;
   logic [31:0]   rd_val;

   pa_sysmap_busif_dec u_dec (
      .addr (addr_q),
      .dec  (dec)
   );

   // The access completes only in a cycle where no reset-sample is in progress.
   assign access_go = (state == ST_ACCESS) && !ifu_sysmap_rst_sample;
   assign blocked   = write_q && lock && (dec.kind == KIND_BASE || dec.kind == KIND_FLG);
   assign acc_err   = !dec.valid || blocked;
   assign wr_ok     = access_go && write_q && dec.valid && !blocked;

   assign busif_base_addr_updt = (wr_ok && dec.kind == KIND_BASE) ? dec.region : '0;
   assign busif_flg_updt       = (wr_ok && dec.kind == KIND_FLG)  ? dec.region : '0;

`ifdef SYSMAP_WR_LOCK_EN
   logic lock_q;
   logic lock_set;

   assign lock_set = wr_ok && (dec.kind == KIND_LOCK) && busif_wdata[0];

   // Sticky: only cpurst_b clears it.
   always_ff @(posedge sysmap_clk or negedge cpurst_b) begin
      if (!cpurst_b)     lock_q <= 1'b0;
      else if (lock_set) lock_q <= 1'b1;
   end

   assign lock = lock_q;
`else
   assign lock = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < REGION_NUM; i++) begin
         if (dec.region[i]) begin
            rd_val = (dec.kind == KIND_FLG) ? busif_flg_values[32*i +: 32]
                                            : busif_base_addr_values[32*i +: 32];
         end
      end
      if (dec.kind == KIND_LOCK) rd_val = {31'h0, lock};
   end

   always_ff @(posedge sysmap_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state                <= ST_IDLE;
         addr_q               <= '0;
         write_q              <= 1'b0;
         busif_wdata          <= '0;
         bus.sysmap_bus_ready <= 1'b0;
         bus.sysmap_bus_err   <= 1'b0;
         bus.sysmap_bus_rdata <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same clock edge.
         bus.sysmap_bus_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.bus_sysmap_sel) begin
                  addr_q      <= bus.bus_sysmap_addr;
                  write_q     <= bus.bus_sysmap_write;
                  busif_wdata <= bus.bus_sysmap_wdata;
                  state       <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!ifu_sysmap_rst_sample) begin
                  bus.sysmap_bus_ready <= 1'b1;
                  bus.sysmap_bus_err   <= acc_err;
                  bus.sysmap_bus_rdata <= write_q ? 32'h0 : rd_val;
                  state                <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pa_sysmap_busif.sv
// Self-checking bench for pa_sysmap_busif: timeline model plus directed literal checks.
// Lock scenarios run when SYSMAP_WR_LOCK_EN is defined.
module tb_pa_sysmap_busif;

`ifdef SYSMAP_WR_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic         sysmap_clk = 1'b0;
   logic         cpurst_b   = 1'b0;
   logic         rst_sample;
   logic [255:0] base_values;
   logic [255:0] flg_values;
   logic [7:0]   base_updt;
   logic [7:0]   flg_updt;
   logic [31:0]  wdata_out;

   always #5 sysmap_clk = ~sysmap_clk;

   pa_sysmap_busif_if bus ();

   pa_sysmap_busif dut (
      .sysmap_clk             (sysmap_clk),
      .cpurst_b               (cpurst_b),
      .bus                    (bus),
      .ifu_sysmap_rst_sample  (rst_sample),
      .busif_base_addr_values (base_values),
      .busif_flg_values       (flg_values),
      .busif_base_addr_updt   (base_updt),
      .busif_flg_updt         (flg_updt),
      .busif_wdata            (wdata_out)
   );

   // ---------------- model state ----------------
   logic [31:0] base_arr [8];
   logic [31:0] flg_arr  [8];
   bit          model_lock;

   always_comb begin
      base_values = '0;
      flg_values  = '0;
      for (int i = 0; i < 8; i++) begin
         base_values[32*i +: 32] = base_arr[i];
         flg_values[32*i +: 32]  = flg_arr[i];
      end
   end

   typedef struct {
      bit          err;
      logic [31:0] rdata;
      logic [7:0]  base_m;
      logic [7:0]  flg_m;
   } outcome_t;

   // Outcome of one transaction computed straight from the register map rules.
   function automatic outcome_t model_txn(input logic wr, input logic [11:0] a, input logic [31:0] wd);
      outcome_t o;
      int       off;
      int       r;
      bit       is_flg;
      o   = '{err: 1'b0, rdata: 32'h0, base_m: 8'h0, flg_m: 8'h0};
      off = int'(a) & 'hFFC;
      if (off < 'h40) begin
         r      = off / 8;
         is_flg = (off % 8) == 4;
         if (!wr)            o.rdata = is_flg ? flg_arr[r] : base_arr[r];
         else if (model_lock) o.err  = 1'b1;
         else if (is_flg)     o.flg_m  = 8'(1 << r);
         else                 o.base_m = 8'(1 << r);
      end else if (LOCK_EN && off == 'h40) begin
         if (!wr)        o.rdata = {31'h0, model_lock};
         else if (wd[0]) model_lock = 1'b1;
      end else begin
         o.err = 1'b1;
      end
      return o;
   endfunction

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   bit          chk_en   = 1'b0;
   bit          chk_data = 1'b0;
   bit          chk_wd   = 1'b0;
   logic [7:0]  exp_base = '0;
   logic [7:0]  exp_flg  = '0;
   logic        exp_ready = 1'b0;
   logic        exp_err   = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] exp_wd    = '0;

   always @(negedge sysmap_clk) begin
      if (chk_en) begin
         check("base_updt", 32'(base_updt), 32'(exp_base));
         check("flg_updt", 32'(flg_updt), 32'(exp_flg));
         check("ready", 32'(bus.sysmap_bus_ready), 32'(exp_ready));
         if (chk_data) begin
            check("err", 32'(bus.sysmap_bus_err), 32'(exp_err));
            check("rdata", bus.sysmap_bus_rdata, exp_rdata);
         end
         if (chk_wd) check("busif_wdata", wdata_out, exp_wd);
      end
   end

   // Event log used by the literal latency/value checks.
   int          cyc = 0;
   int          strobe_cyc, strobe_cnt = 0, ready_cyc = 0, prev_ready_cyc = 0, ready_cnt = 0;
   logic [7:0]  strobe_base, strobe_flg;
   logic        last_err;
   logic [31:0] last_rdata;
   int          sel_cyc;

   always @(posedge sysmap_clk) cyc <= cyc + 1;

   always @(negedge sysmap_clk) begin
      if (|base_updt || |flg_updt) begin
         strobe_cyc  = cyc;
         strobe_base = base_updt;
         strobe_flg  = flg_updt;
         strobe_cnt++;
      end
      if (bus.sysmap_bus_ready) begin
         prev_ready_cyc = ready_cyc;
         ready_cyc      = cyc;
         last_err       = bus.sysmap_bus_err;
         last_rdata     = bus.sysmap_bus_rdata;
         ready_cnt++;
      end
   end

   task automatic idle_exp();
      exp_base  = '0;
      exp_flg   = '0;
      exp_ready = 1'b0;
      chk_data  = 1'b0;
      chk_wd    = 1'b0;
   endtask

   // Called #1 after a rising edge with the DUT idle; returns #1 after the edge leaving RESP.
   task automatic do_txn(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                         input int stall, input bit hold);
      outcome_t o;
      o = model_txn(wr, a, wd);
      bus.bus_sysmap_sel   = 1'b1;
      bus.bus_sysmap_write = wr;
      bus.bus_sysmap_addr  = a;
      bus.bus_sysmap_wdata = wd;
      rst_sample           = 1'b0;
      idle_exp();
      @(posedge sysmap_clk); #1;
      sel_cyc = cyc;
      // Request fields change after the sample edge; only the captured values may matter.
      bus.bus_sysmap_write = ~wr;
      bus.bus_sysmap_addr  = 12'h5A4;
      bus.bus_sysmap_wdata = ~wd;
      chk_wd = 1'b1;
      exp_wd = wd;
      for (int k = 0; k <= stall; k++) begin
         rst_sample = (k < stall);
         exp_base   = (k == stall) ? o.base_m : 8'h0;
         exp_flg    = (k == stall) ? o.flg_m  : 8'h0;
         @(posedge sysmap_clk); #1;
      end
      rst_sample = 1'b0;
      exp_base   = '0;
      exp_flg    = '0;
      exp_ready  = 1'b1;
      chk_data   = 1'b1;
      exp_err    = o.err;
      exp_rdata  = o.rdata;
      @(posedge sysmap_clk); #1;
      idle_exp();
      if (!hold) begin
         bus.bus_sysmap_sel   = 1'b0;
         bus.bus_sysmap_write = 1'b0;
         bus.bus_sysmap_addr  = '0;
         bus.bus_sysmap_wdata = '0;
      end
   endtask

   task automatic apply_reset(input int cycles);
      cpurst_b   = 1'b0;
      model_lock = 1'b0;
      bus.bus_sysmap_sel = 1'b0;
      idle_exp();
      chk_data  = 1'b1;
      exp_err   = 1'b0;
      exp_rdata = '0;
      chk_wd    = 1'b1;
      exp_wd    = '0;
      repeat (cycles) @(posedge sysmap_clk);
      #1;
      cpurst_b = 1'b1;
      idle_exp();
   endtask

   int sc0, rc0;

   initial begin
      bus.bus_sysmap_sel   = 1'b0;
      bus.bus_sysmap_write = 1'b0;
      bus.bus_sysmap_addr  = '0;
      bus.bus_sysmap_wdata = '0;
      rst_sample           = 1'b0;
      model_lock           = 1'b0;
      for (int i = 0; i < 8; i++) begin
         base_arr[i] = 32'hB000_0000 | 32'(i * 16 + 3);
         flg_arr[i]  = 32'(8'h40 + i);
      end
      flg_arr[4] = 32'h0000_001C;

      chk_en = 1'b1;
      apply_reset(3);
      check("rst_ready", 32'(bus.sysmap_bus_ready), 32'h0);
      check("rst_rdata", bus.sysmap_bus_rdata, 32'h0);
      check("rst_wdata", wdata_out, 32'h0);
      @(posedge sysmap_clk); #1;

      // Base write to region 3.
      sc0 = strobe_cnt;
      do_txn(1'b1, 12'h018, 32'h0001_2345, 0, 1'b0);
      check("w18_strobe", 32'(strobe_base), 32'h08);
      check("w18_strobe_lat", 32'(strobe_cyc + 1 - sel_cyc), 32'd1);
      check("w18_ready_lat", 32'(ready_cyc + 1 - sel_cyc), 32'd2);
      check("w18_err", 32'(last_err), 32'h0);
      check("w18_strobe_cnt", 32'(strobe_cnt - sc0), 32'd1);

      // Flag read of region 4, and the same register with non-zero low address bits.
      sc0 = strobe_cnt;
      do_txn(1'b0, 12'h024, 32'hFFFF_FFFF, 0, 1'b0);
      check("r24_rdata", last_rdata, 32'h0000_001C);
      check("r24_err", 32'(last_err), 32'h0);
      check("r24_no_strobe", 32'(strobe_cnt - sc0), 32'd0);
      do_txn(1'b0, 12'h027, 32'h0, 0, 1'b0);
      check("r27_rdata", last_rdata, 32'h0000_001C);

      // Unmapped read.
      do_txn(1'b0, 12'h3FC, 32'h0, 0, 1'b0);
      check("r3fc_err", 32'(last_err), 32'h1);
      check("r3fc_rdata", last_rdata, 32'h0);

      // Reset-sample stall of three cycles.
      do_txn(1'b1, 12'h000, 32'hCAFE_0000, 3, 1'b0);
      check("stall_strobe", 32'(strobe_base), 32'h01);
      check("stall_strobe_lat", 32'(strobe_cyc + 1 - sel_cyc), 32'd4);
      check("stall_ready_lat", 32'(ready_cyc + 1 - sel_cyc), 32'd5);

      // Region 7 flag write, base read, unmapped write.
      do_txn(1'b1, 12'h03C, 32'h0000_00A5, 0, 1'b0);
      check("w3c_strobe", 32'(strobe_flg), 32'h80);
      do_txn(1'b0, 12'h010, 32'h0, 0, 1'b0);
      check("r10_rdata", last_rdata, 32'hB000_0023);
      sc0 = strobe_cnt;
      do_txn(1'b1, 12'h044, 32'h1234_5678, 0, 1'b0);
      check("w44_err", 32'(last_err), 32'h1);
      check("w44_no_strobe", 32'(strobe_cnt - sc0), 32'd0);

      // Back-to-back reads with sel held.
      do_txn(1'b0, 12'h024, 32'h0, 0, 1'b1);
      do_txn(1'b0, 12'h008, 32'h0, 0, 1'b1);
      check("b2b_gap1", 32'(ready_cyc - prev_ready_cyc), 32'd3);
      do_txn(1'b0, 12'h03C, 32'h0, 0, 1'b0);
      check("b2b_gap2", 32'(ready_cyc - prev_ready_cyc), 32'd3);
      check("b2b_rdata", last_rdata, 32'h0000_0047);

`ifdef SYSMAP_WR_LOCK_EN
      do_txn(1'b1, 12'h040, 32'h0, 0, 1'b0);
      check("lock0_err", 32'(last_err), 32'h0);
      do_txn(1'b0, 12'h040, 32'h0, 0, 1'b0);
      check("lock0_rd", last_rdata, 32'h0);
      do_txn(1'b1, 12'h040, 32'h1, 0, 1'b0);
      sc0 = strobe_cnt;
      do_txn(1'b1, 12'h008, 32'h5555_0000, 0, 1'b0);
      check("locked_w08_err", 32'(last_err), 32'h1);
      do_txn(1'b1, 12'h00C, 32'h5555_0000, 0, 1'b0);
      check("locked_w0c_err", 32'(last_err), 32'h1);
      check("locked_no_strobe", 32'(strobe_cnt - sc0), 32'd0);
      do_txn(1'b0, 12'h040, 32'h0, 0, 1'b0);
      check("lock1_rd", last_rdata, 32'h1);
      do_txn(1'b0, 12'h008, 32'h0, 0, 1'b0);
      check("locked_rd_err", 32'(last_err), 32'h0);
      apply_reset(2);
      @(posedge sysmap_clk); #1;
      do_txn(1'b1, 12'h008, 32'h5555_0000, 0, 1'b0);
      check("unlock_strobe", 32'(strobe_base), 32'h02);
      check("unlock_err", 32'(last_err), 32'h0);
`endif

      // Reset asserted in ACCESS: nothing may follow after release.
      sc0 = strobe_cnt;
      rc0 = ready_cnt;
      bus.bus_sysmap_sel   = 1'b1;
      bus.bus_sysmap_write = 1'b1;
      bus.bus_sysmap_addr  = 12'h008;
      bus.bus_sysmap_wdata = 32'h7777_7777;
      @(posedge sysmap_clk); #1;
      apply_reset(2);
      repeat (6) @(posedge sysmap_clk);
      #1;
      check("rst_abort_strobe", 32'(strobe_cnt - sc0), 32'd0);
      check("rst_abort_ready", 32'(ready_cnt - rc0), 32'd0);

      // Normal service resumes after the abort.
      do_txn(1'b1, 12'h02C, 32'h0000_0003, 0, 1'b0);
      check("post_rst_strobe", 32'(strobe_flg), 32'h20);
      repeat (2) @(posedge sysmap_clk);
      #1;
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
